// File: rtl/candy_crush_cc_if.sv
// candy_crush_cc_if: board-load, action and result signals of the candy crush engine
interface candy_crush_cc_if;
  logic       in_valid_1;
  logic [2:0] in_color;
  logic       in_valid_2;
  logic [5:0] in_starting_pos;
  logic [1:0] in_action;
  logic       in_stripe;
  logic       out_valid;
  logic [6:0] out_score;
  modport master (output in_valid_1, in_color, in_valid_2, in_starting_pos, in_action, in_stripe,
                  input out_valid, out_score);
  modport slave (input in_valid_1, in_color, in_valid_2, in_starting_pos, in_action, in_stripe,
                 output out_valid, out_score);
endinterface

// File: rtl/candy_crush_cc.sv
// candy_crush_cc: 6x6 match-3 engine with cascade and gravity, reports the game score
// CC_STRIPE_EN enables striped candies that clear their whole row when eliminated
module candy_crush_cc (
  input logic clk,
  input logic rst_n,
  candy_crush_cc_if.slave cc
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACT, SWAP, MATCH, FALL, OUT} state_t;
  state_t state;
  logic [2:0] board [36];
  logic [2:0] nb [36];
  logic [5:0] cnt;
  logic [5:0] bpos [4];
  logic [1:0] bact [4];
  logic [2:0] wcnt, rcnt;
  logic [6:0] score, gain;
  logic [35:0] m, clr, nz;
  logic [5:0] p, q;
  logic [2:0] pr, pc;
  logic [1:0] a;
  logic ok;
  int w;
`ifdef CC_STRIPE_EN
  logic bstr [4];
  logic [35:0] stripe, ns;
`endif
  always_comb begin
    p = bpos[rcnt[1:0]];
    a = bact[rcnt[1:0]];
    pr = 3'(p / 6'd6);
    pc = 3'(p % 6'd6);
    q = a == 2'd0 ? p - 6'd6 : a == 2'd1 ? p + 6'd6 : a == 2'd2 ? p - 6'd1 : p + 6'd1;
    ok = p < 6'd36 && (a == 2'd0 ? pr != 3'd0 : a == 2'd1 ? pr != 3'd5 : a == 2'd2 ? pc != 3'd0 : pc != 3'd5)
         && board[p] != 3'd0 && board[q] != 3'd0;
  end
  always_comb begin
    m = '0;
    nz = '0;
    gain = '0;
    for (int i = 0; i < 36; i++) nz[i] = board[i] != 3'd0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        if (nz[r*6+c] && board[r*6+c] == board[r*6+c+1] && board[r*6+c] == board[r*6+c+2]) m[r*6+c +: 3] = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        if (nz[r*6+c] && board[r*6+c] == board[r*6+c+6] && board[r*6+c] == board[r*6+c+12]) begin
          m[r*6+c] = 1'b1;
          m[r*6+c+6] = 1'b1;
          m[r*6+c+12] = 1'b1;
        end
    clr = m;
`ifdef CC_STRIPE_EN
    for (int r = 0; r < 6; r++) if (|(clr[r*6 +: 6] & stripe[r*6 +: 6])) clr[r*6 +: 6] = 6'h3f;
`endif
    clr = clr & nz;
    for (int i = 0; i < 36; i++) gain = gain + 7'(clr[i]);
  end
  // each column is compacted toward row 5 in a single step
  always_comb begin
    w = 0;
    for (int i = 0; i < 36; i++) nb[i] = 3'd0;
`ifdef CC_STRIPE_EN
    ns = '0;
`endif
    for (int c = 0; c < 6; c++) begin
      w = 5;
      for (int r = 5; r >= 0; r--)
        if (board[r*6+c] != 3'd0) begin
          nb[w*6+c] = board[r*6+c];
`ifdef CC_STRIPE_EN
          ns[w*6+c] = stripe[r*6+c];
`endif
          w = w - 1;
        end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      rcnt <= '0;
      score <= '0;
      cc.out_valid <= 1'b0;
      cc.out_score <= '0;
      for (int i = 0; i < 36; i++) board[i] <= '0;
      for (int j = 0; j < 4; j++) begin
        bpos[j] <= '0;
        bact[j] <= '0;
`ifdef CC_STRIPE_EN
        bstr[j] <= 1'b0;
`endif
      end
`ifdef CC_STRIPE_EN
      stripe <= '0;
`endif
    end else begin
      if (cc.in_valid_2 && !wcnt[2]) begin
        bpos[wcnt[1:0]] <= cc.in_starting_pos;
        bact[wcnt[1:0]] <= cc.in_action;
`ifdef CC_STRIPE_EN
        bstr[wcnt[1:0]] <= cc.in_stripe;
`endif
        wcnt <= wcnt + 3'd1;
      end
      case (state)
        IDLE: if (cc.in_valid_1) begin
          board[0] <= cc.in_color;
          cnt <= 6'd1;
          score <= '0;
          wcnt <= '0;
          rcnt <= '0;
`ifdef CC_STRIPE_EN
          stripe <= '0;
`endif
          state <= LOAD;
        end
        LOAD: if (cc.in_valid_1) begin
          board[cnt] <= cc.in_color;
          cnt <= cnt + 6'd1;
        end else state <= WAIT_ACT;
        WAIT_ACT: if (rcnt[2]) begin
          cc.out_valid <= 1'b1;
          cc.out_score <= score;
          state <= OUT;
        end else if (rcnt < wcnt) state <= SWAP;
        SWAP: begin
          if (ok) begin
            board[p] <= board[q];
            board[q] <= board[p];
`ifdef CC_STRIPE_EN
            stripe[p] <= stripe[q];
            stripe[q] <= bstr[rcnt[1:0]] | stripe[p];
`endif
          end
          state <= MATCH;
        end
        MATCH: if (|clr) begin
          for (int i = 0; i < 36; i++) if (clr[i]) board[i] <= 3'd0;
`ifdef CC_STRIPE_EN
          stripe <= stripe & ~clr;
`endif
          score <= score + gain;
          state <= FALL;
        end else begin
          rcnt <= rcnt + 3'd1;
          state <= WAIT_ACT;
        end
        FALL: begin
          board <= nb;
`ifdef CC_STRIPE_EN
          stripe <= ns;
`endif
          state <= MATCH;
        end
        OUT: begin
          cc.out_valid <= 1'b0;
          cc.out_score <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_candy_crush_cc.sv
// tb_candy_crush_cc: directed games with a score scoreboard checked by an independent monitor
module tb_candy_crush_cc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  candy_crush_cc_if cc();
  candy_crush_cc dut (.clk(clk), .rst_n(rst_n), .cc(cc));
  int total = 0;
  int bad = 0;
  int exp_q[$];
  int e;
  logic prev_v = 1'b0;
  logic [2:0] b [36];
  logic [5:0] ap [4];
  logic [1:0] aa [4];
  logic as_ [4];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_all;
    for (int k = 0; k < 36; k++) b[k] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ap[i] = 6'd0;
      aa[i] = 2'd0;
      as_[i] = 1'b0;
    end
  endtask
  task automatic act(input int i, input int pos, input int dir, input bit s);
    ap[i] = 6'(pos);
    aa[i] = 2'(dir);
    as_[i] = s;
  endtask
  task automatic row5(input int c0, input int c1, input int c2, input int c3, input int c4, input int c5);
    b[30] = 3'(c0); b[31] = 3'(c1); b[32] = 3'(c2);
    b[33] = 3'(c3); b[34] = 3'(c4); b[35] = 3'(c5);
  endtask
  task automatic play(input int expv, input bit check);
    if (check) exp_q.push_back(expv);
    cc.in_valid_1 = 1'b1;
    for (int k = 0; k < 36; k++) begin
      cc.in_color = b[k];
      tick;
    end
    cc.in_valid_1 = 1'b0;
    cc.in_color = 3'd0;
    tick;
    for (int i = 0; i < 4; i++) begin
      cc.in_valid_2 = 1'b1;
      cc.in_starting_pos = ap[i];
      cc.in_action = aa[i];
      cc.in_stripe = as_[i];
      tick;
    end
    cc.in_valid_2 = 1'b0;
    cc.in_starting_pos = 6'd0;
    cc.in_action = 2'd0;
    cc.in_stripe = 1'b0;
    if (check) begin
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
        tick;
        n++;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL latency: no out_valid within %0d cycles, want pulse with score %0d", n, expv);
        exp_q.delete();
      end
      repeat (3) tick;
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      if (cc.out_valid !== 1'b0 || cc.out_score !== 7'd0) begin
        bad++;
        $display("FAIL reset_out: out_valid=%b out_score=%0d, want 0 and 0", cc.out_valid, cc.out_score);
      end
    end else if (cc.out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: out_score=%0d with no game pending", cc.out_score);
      end else begin
        e = exp_q.pop_front();
        if (cc.out_score !== 7'(e)) begin
          bad++;
          $display("FAIL score: got %0d want %0d", cc.out_score, e);
        end
      end
      if (prev_v || cc.in_valid_1 || cc.in_valid_2) begin
        bad++;
        $display("FAIL pulse_shape: prev_valid=%b in_valid_1=%b in_valid_2=%b, want 0 0 0", prev_v, cc.in_valid_1, cc.in_valid_2);
      end
    end else if (cc.out_score !== 7'd0) begin
      total++;
      bad++;
      $display("FAIL idle_score: got %0d want 0 while out_valid=0", cc.out_score);
    end
    prev_v = cc.out_valid;
  end
  initial begin
    cc.in_valid_1 = 1'b0;
    cc.in_color = 3'd0;
    cc.in_valid_2 = 1'b0;
    cc.in_starting_pos = 6'd0;
    cc.in_action = 2'd0;
    cc.in_stripe = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    clear_all;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) b[r*6+c] = 3'(((r + 2*c) % 4) + 1);
    play(0, 1'b1);
    clear_all;
    row5(1, 1, 2, 1, 3, 4);
    act(0, 32, 3, 1'b0);
    play(3, 1'b1);
    clear_all;
    b[12] = 3'd5; b[18] = 3'd5;
    b[24] = 3'd1; b[25] = 3'd1; b[26] = 3'd2; b[27] = 3'd1;
    row5(5, 6, 7, 3, 0, 0);
    act(0, 26, 3, 1'b0);
    play(6, 1'b1);
    clear_all;
    row5(1, 2, 1, 1, 0, 0);
    b[25] = 3'd1; b[19] = 3'd1;
    act(0, 31, 2, 1'b0);
    play(5, 1'b1);
    clear_all;
    row5(1, 1, 2, 1, 3, 4);
    act(0, 33, 2, 1'b1);
`ifdef CC_STRIPE_EN
    play(6, 1'b1);
`else
    play(3, 1'b1);
`endif
    clear_all;
    row5(1, 2, 3, 1, 1, 0);
    act(0, 30, 3, 1'b0);
    act(1, 31, 3, 1'b0);
    play(3, 1'b1);
    clear_all;
    row5(2, 1, 1, 0, 1, 0);
    b[29] = 3'd1;
    act(0, 33, 3, 1'b0);
    act(1, 29, 3, 1'b0);
    act(3, 0, 2, 1'b0);
    play(0, 1'b1);
    clear_all;
    row5(1, 1, 2, 1, 3, 4);
    act(0, 32, 3, 1'b0);
    play(0, 1'b0);
    tick;
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (300) tick;
    clear_all;
    b[12] = 3'd5; b[18] = 3'd5;
    b[24] = 3'd1; b[25] = 3'd1; b[26] = 3'd2; b[27] = 3'd1;
    row5(5, 6, 7, 3, 0, 0);
    act(0, 26, 3, 1'b0);
    play(6, 1'b1);
    repeat (5) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
